f1_inv_iter: RTL and testbench
==============================

F1_INV_ITER -- requirements
Module: f1_inv_iter

Interface
REQ-001 Parameter: ROUNDS, 8, number of inverse rounds per block (legal range 1..16).
REQ-002 Parameter: KA_W, 4, round-key address width; must satisfy 2**KA_W >= ROUNDS.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: key_we  input  1  round-key write strobe.
REQ-006 Port: key_addr  input  KA_W  round-key index; writes with key_addr >= ROUNDS are ignored.
REQ-007 Port: key_data  input  32 [0:31]  round-key value, bit 0 = MSB.
REQ-008 Port: in_valid  input  1  ciphertext word offered.
REQ-009 Port: in_ready  output  1  block can accept a word.
REQ-010 Port: in_data  input  32 [0:31]  ciphertext word.
REQ-011 Port: out_valid  output  1  recovered word available.
REQ-012 Port: out_ready  input  1  consumer accepts the word.
REQ-013 Port: out_data  output  32 [0:31]  recovered plaintext word.

Function
REQ-014 Inverse round: given W and key K, bytes B0=W[0:7], B1=W[8:15], B2=W[16:23], B3=W[24:31]; T[0:7]=B0 rotated left 3; T[8:15]=B1 nibble-swapped; T[16:23]=B2 rotated right 1; T[24:31]=B3; result = T xor K.
REQ-015 Block operation: state=in_data, then apply the inverse round with keys key[ROUNDS-1], key[ROUNDS-2], ..., key[0] in that order, one round per clock.
REQ-016 FSM states: IDLE, RUN, DONE; IDLE->RUN on in_valid&&in_ready; RUN->DONE after the round using key[0]; DONE->IDLE on out_valid&&out_ready.
REQ-017 in_ready = 1 only in IDLE; out_valid = 1 only in DONE; out_data = internal state register in DONE, holds value while out_ready=0.
REQ-018 Latency: out_valid rises exactly ROUNDS+1 cycles after the cycle of input acceptance; throughput one block per ROUNDS+2 cycles with out_ready held high.
REQ-019 Round counter: KA_W bits, loaded with ROUNDS-1 on acceptance, decrements each RUN cycle, no wrap (RUN exits at 0).
REQ-020 Key writes are honoured only in IDLE; key_we in RUN or DONE is ignored (keys stable during a block).
REQ-021 Simultaneous key_we and input acceptance in IDLE: write takes effect, and the block uses the new key value.
REQ-022 in_valid during RUN/DONE is not consumed; in_data is sampled only on the accepting edge.
REQ-023 out_ready asserted outside DONE has no effect.

Reset
REQ-024 On rst=1 at a clock edge: FSM -> IDLE, counter -> 0, state register -> 0x00000000, all keys -> 0x00000000, in_ready=1, out_valid=0, out_data=0x00000000 from the next cycle.
REQ-025 rst in RUN or DONE aborts the block; the partial result is discarded and never presented.
REQ-026 rst has priority over key_we and both handshakes in the same cycle.

Structure
REQ-027 Shared package f1_pkg holds the 32-bit word width constant, the FSM state encoding (IDLE/RUN/DONE), and the per-byte rotation amounts (3, nibble swap, 1, 0).
REQ-028 Combinational sub-module f1_inv (inputs W, K; output 32-bit result) implements REQ-014; f1_inv_iter instantiates it once and iterates it.
REQ-029 Forward-round identity: F1 applied to f1_inv(W,K) with key K returns W for all W, K.

Verification
REQ-030 ROUNDS=1, key[0]=0x00000000, in_data=0x01020304 -> out_data=0x08208104, out_valid at 2 cycles after acceptance.
REQ-031 ROUNDS=1, key[0]=0xFFFFFFFF, in_data=0x01020304 -> out_data=0xF7DF7EFB.
REQ-032 ROUNDS=8, random keys, plaintext encrypted by 8 forward F1 rounds (key[0]..key[7]) -> out_data equals the original plaintext; 1000 random vectors.
REQ-033 out_ready held 0 for 5 cycles in DONE -> out_data and out_valid stable, in_ready=0, a second in_valid is not accepted until handoff.
REQ-034 key_we to key[3] during RUN -> ignored, result matches the old key; rst asserted mid-RUN -> next cycle IDLE, in_ready=1, out_valid=0, keys all 0.

Source files
------------

// File: rtl/f1_pkg.sv
// f1_pkg: shared word width, FSM encoding and per-byte rotation amounts for F1
package f1_pkg;
  localparam int WORD_W = 32;
  localparam int ROT_B0 = 3;
  localparam int ROT_B1 = 4;
  localparam int ROT_B2 = 1;
  localparam int ROT_B3 = 0;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [7:0] rotl8(input logic [7:0] b, input int r);
    return (b << r) | (b >> (8 - r));
  endfunction
  function automatic logic [7:0] rotr8(input logic [7:0] b, input int r);
    return (b >> r) | (b << (8 - r));
  endfunction
endpackage

// File: rtl/f1_inv.sv
// f1_inv: one combinational F1 inverse round (byte rotations/nibble swap, then key xor)
module f1_inv
  import f1_pkg::*;
(
  input  logic [0:WORD_W-1] w,
  input  logic [0:WORD_W-1] k,
  output logic [0:WORD_W-1] r
);
  // a nibble swap is a rotation by four
  assign r = {rotl8(w[0:7], ROT_B0), rotl8(w[8:15], ROT_B1),
              rotr8(w[16:23], ROT_B2), rotl8(w[24:31], ROT_B3)} ^ k;
endmodule

// File: rtl/f1_inv_iter.sv
// f1_inv_iter: iterates f1_inv over ROUNDS stored keys, last key first, one round per clock
module f1_inv_iter
  import f1_pkg::*;
#(
  parameter int ROUNDS = 8,
  parameter int KA_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_we,
  input  logic [KA_W-1:0]   key_addr,
  input  logic [0:WORD_W-1] key_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:WORD_W-1] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:WORD_W-1] out_data
);
  state_t            state, state_n;
  logic [KA_W-1:0]   cnt;
  logic [0:WORD_W-1] st, rnd;
  logic [0:WORD_W-1] keys [ROUNDS];
  logic              accept, key_ok;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign out_data  = out_valid ? st : '0;
  assign accept    = in_valid && in_ready;
  // keys only change between blocks so a running block sees a stable schedule
  assign key_ok    = in_ready && key_we && ({1'b0, key_addr} < (KA_W+1)'(ROUNDS));
  f1_inv u_inv (.w(st), .k(keys[cnt]), .r(rnd));
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (accept ? RUN : IDLE)
            : state == RUN  ? (cnt == '0 ? DONE : RUN)
            : (out_ready ? IDLE : DONE);
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      st  <= '0;
      for (int i = 0; i < ROUNDS; i++) keys[i] <= '0;
    end else begin
      if (key_ok) keys[key_addr] <= key_data;
      if (accept) begin
        st  <= in_data;
        cnt <= KA_W'(ROUNDS - 1);
      end else if (state == RUN) begin
        st  <= rnd;
        cnt <= cnt == '0 ? cnt : cnt - 1'b1;
      end
    end
endmodule

// File: tb/tb_f1_inv_iter.sv
// tb_f1_inv_iter: directed + random scoreboard bench for f1_inv_iter (ROUNDS=8 and ROUNDS=1 instances)
module tb_f1_inv_iter;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic a_key_we = 0, a_in_valid = 0, a_out_ready = 0, a_in_ready, a_out_valid;
  logic [3:0] a_key_addr = 0;
  logic [31:0] a_key_data = 0, a_in_data = 0, a_out_data;
  logic b_key_we = 0, b_in_valid = 0, b_out_ready = 0, b_in_ready, b_out_valid;
  logic [3:0] b_key_addr = 0;
  logic [31:0] b_key_data = 0, b_in_data = 0, b_out_data;
  int checks = 0, errors = 0;
  logic [31:0] q8[$], q1[$];
  logic [31:0] kq [8];
  logic [31:0] p;

  f1_inv_iter #(.ROUNDS(8), .KA_W(4)) u8 (
    .clk(clk), .rst(rst), .key_we(a_key_we), .key_addr(a_key_addr), .key_data(a_key_data),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data));
  f1_inv_iter #(.ROUNDS(1), .KA_W(4)) u1 (
    .clk(clk), .rst(rst), .key_we(b_key_we), .key_addr(b_key_addr), .key_data(b_key_data),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  // forward F1 round: xor key, then undo the inverse byte permutations
  function automatic logic [31:0] fwd(input logic [31:0] y, input logic [31:0] k);
    logic [31:0] t;
    t = y ^ k;
    return {t[26:24], t[31:27], t[19:16], t[23:20], t[14:8], t[15], t[7:0]};
  endfunction
  function automatic logic [31:0] enc(input logic [31:0] pt);
    logic [31:0] c;
    c = pt;
    for (int i = 0; i < 8; i++) c = fwd(c, kq[i]);
    return c;
  endfunction
  task automatic wkey8(input logic [3:0] a, input logic [31:0] d);
    a_key_we = 1; a_key_addr = a; a_key_data = d;
    tick;
    a_key_we = 0;
  endtask
  task automatic send8(input logic [31:0] c, input logic [31:0] exp);
    int n = 0;
    while (!a_in_ready && n < 50) begin tick; n++; end
    chk1("u8_in_ready", a_in_ready, 1'b1);
    a_in_valid = 1; a_in_data = c;
    tick;
    a_in_valid = 0;
    q8.push_back(exp);
  endtask
  task automatic recv8(input int lat);
    int n = 0;
    while (!a_out_valid && n < 50) begin tick; n++; end
    chk("u8_latency", n, lat);
    chk1("u8_out_valid", a_out_valid, 1'b1);
    chk("u8_out_data", a_out_data, q8.pop_front());
    a_out_ready = 1;
    tick;
    a_out_ready = 0;
    chk1("u8_idle_ready", a_in_ready, 1'b1);
    chk1("u8_idle_valid", a_out_valid, 1'b0);
  endtask
  task automatic send1(input logic [31:0] c, input logic [31:0] exp);
    int n = 0;
    while (!b_in_ready && n < 50) begin tick; n++; end
    chk1("u1_in_ready", b_in_ready, 1'b1);
    b_in_valid = 1; b_in_data = c;
    tick;
    b_in_valid = 0;
    q1.push_back(exp);
  endtask
  task automatic recv1;
    int n = 0;
    while (!b_out_valid && n < 50) begin tick; n++; end
    chk("u1_latency", n, 1);
    chk1("u1_out_valid", b_out_valid, 1'b1);
    chk("u1_out_data", b_out_data, q1.pop_front());
    b_out_ready = 1;
    tick;
    b_out_ready = 0;
    chk1("u1_idle_ready", b_in_ready, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) kq[i] = '0;
    tick; tick;
    rst = 0;
    chk1("rst_in_ready", a_in_ready, 1'b1);
    chk1("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_out_data", a_out_data, 32'h0);
    chk1("rst_u1_in_ready", b_in_ready, 1'b1);
    chk("rst_u1_out_data", b_out_data, 32'h0);
    // ROUNDS=1: zero key, then an out-of-range write that must be dropped
    b_key_we = 1; b_key_addr = 0; b_key_data = 32'h0;
    tick;
    b_key_addr = 1; b_key_data = 32'hFFFFFFFF;
    tick;
    b_key_we = 0;
    send1(32'h01020304, 32'h08208104);
    recv1;
    // key write coinciding with acceptance is used by that block
    b_key_we = 1; b_key_addr = 0; b_key_data = 32'hFFFFFFFF;
    send1(32'h01020304, 32'hF7DF7EFB);
    b_key_we = 0;
    recv1;
    // ROUNDS=8: random schedule, random plaintexts
    for (int i = 0; i < 8; i++) begin
      kq[i] = $urandom;
      wkey8(4'(i), kq[i]);
    end
    for (int v = 0; v < 1000; v++) begin
      p = $urandom;
      send8(enc(p), p);
      recv8(8);
    end
    // backpressure in DONE with a competing in_valid
    p = $urandom;
    send8(enc(p), p);
    a_in_valid = 1; a_in_data = $urandom;
    repeat (8) tick;
    for (int i = 0; i < 5; i++) begin
      chk1("hold_valid", a_out_valid, 1'b1);
      chk("hold_data", a_out_data, p);
      chk1("hold_in_ready", a_in_ready, 1'b0);
      tick;
    end
    a_in_valid = 0;
    recv8(0);
    // key write during RUN is ignored
    p = $urandom;
    send8(enc(p), p);
    wkey8(4'd3, ~kq[3]);
    recv8(7);
    // reset mid-RUN aborts and clears keys
    p = $urandom;
    send8(enc(p), p);
    tick; tick;
    rst = 1;
    tick;
    rst = 0;
    q8.delete();
    for (int i = 0; i < 8; i++) kq[i] = '0;
    chk1("abort_in_ready", a_in_ready, 1'b1);
    chk1("abort_out_valid", a_out_valid, 1'b0);
    chk("abort_out_data", a_out_data, 32'h0);
    p = $urandom;
    send8(enc(p), p);
    recv8(8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
